// File: rtl/prng_word_packer.sv
// rtl/prng_word_packer.sv - packs sampled keystream bits into words and buffers them in a small FIFO
// Optional monobit health test is enabled by defining HEALTH_TEST_EN.
module prng_word_packer #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     Zi,
  input  logic                     bit_valid,
  input  logic                     flush,
  output logic [WORD_W-1:0]        word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     health_fail
);

  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(WORD_W);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [WORD_W-1:0] mem_q [DEPTH];

  logic [WORD_W-1:0] shifted;
  logic              wrap, pop, full, push, we;

  always_comb begin
    shifted   = {asm_q[WORD_W-2:0], Zi};
    wrap      = bit_valid && (bit_cnt_q == LAST_BIT);
    pop       = word_valid && word_ready;
    full      = (count_q == FULL_CNT);
    // A full FIFO still takes a new word when the head leaves on the same edge.
    push      = wrap && (!full || pop);
    we        = 1'b0;
    bit_cnt_d = bit_cnt_q;
    asm_d     = asm_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    if (flush) begin
      bit_cnt_d = '0;
      asm_d     = '0;
      rd_d      = '0;
      wr_d      = '0;
      count_d   = '0;
      ovf_d     = 1'b0;
    end else begin
      if (bit_valid) begin
        asm_d     = shifted;
        bit_cnt_d = wrap ? '0 : bit_cnt_q + BW'(1);
      end
      if (wrap && !push) ovf_d = 1'b1;
      if (pop)  rd_d = rd_q + PW'(1);
      if (push) begin
        wr_d = wr_q + PW'(1);
        we   = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      asm_q     <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      asm_q     <= asm_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      if (we) mem_q[wr_q] <= shifted;
    end
  end

  assign word_valid = (count_q != '0);
  assign word_out   = word_valid ? mem_q[rd_q] : '0;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

`ifdef HEALTH_TEST_EN
  localparam int OW = $clog2(WORD_W + 1);
  localparam logic [OW-1:0] ONES_LO = OW'(WORD_W / 8);
  localparam logic [OW-1:0] ONES_HI = OW'(WORD_W - WORD_W / 8);

  logic [OW-1:0] ones;
  logic          health_q, health_d;

  always_comb begin
    ones = '0;
    for (int i = 0; i < WORD_W; i++) ones = ones + OW'(shifted[i]);
    health_d = health_q;
    if (flush) health_d = 1'b0;
    else if (wrap && ((ones < ONES_LO) || (ones > ONES_HI))) health_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) health_q <= 1'b0;
    else        health_q <= health_d;
  end

  assign health_fail = health_q;
`else
  assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_prng_word_packer.sv
// tb/tb_prng_word_packer.sv - directed scoreboard bench for prng_word_packer
module tb_prng_word_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Zi;
  logic        bit_valid;
  logic        flush;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        health_fail;

  prng_word_packer #(.WORD_W(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Zi         (Zi),
    .bit_valid  (bit_valid),
    .flush      (flush),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] q[$];
  logic [31:0] m_asm;
  int          m_cnt;
  logic        m_ovf;
  logic        m_hf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_asm = '0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_hf  = 1'b0;
  endtask

  task automatic step(input logic bv, input logic z, input logic rdy, input logic fl);
    logic popped;
    bit_valid  = bv;
    Zi         = z;
    word_ready = rdy;
    flush      = fl;
    if (fl) begin
      model_clear();
    end else begin
      popped = rdy && (q.size() != 0);
      if (popped) void'(q.pop_front());
      if (bv) begin
        m_asm = {m_asm[30:0], z};
        m_cnt++;
        if (m_cnt == 32) begin
          m_cnt = 0;
          if (q.size() < 4) q.push_back(m_asm);
          else m_ovf = 1'b1;
`ifdef HEALTH_TEST_EN
          if ($countones(m_asm) < 4 || $countones(m_asm) > 28) m_hf = 1'b1;
`endif
        end
      end
    end
    @(posedge clk);
    #1;
    bit_valid  = 1'b0;
    word_ready = 1'b0;
    flush      = 1'b0;
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("word_valid", 32'(word_valid), 32'(q.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("health_fail", 32'(health_fail), 32'(m_hf));
    if (q.size() != 0) chk("word_out", word_out, q[0]);
  endtask

  task automatic send_word(input logic [31:0] w, input logic last_rdy);
    for (int i = 31; i >= 0; i--) step(1'b1, w[i], (i == 0) ? last_rdy : 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_word_out"}, word_out, 32'h0);
    chk({tag, "_word_valid"}, 32'(word_valid), 32'h0);
    chk({tag, "_fifo_count"}, 32'(fifo_count), 32'h0);
    chk({tag, "_overflow"}, 32'(overflow), 32'h0);
    chk({tag, "_health_fail"}, 32'(health_fail), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    Zi = 1'b0; bit_valid = 1'b0; flush = 1'b0; word_ready = 1'b0;
    model_clear();
    #1;
    check_all_zero("reset");
    #12 rst_n = 1'b1;

    // alternating 1,0,... word; valid only after the 32nd bit
    for (int i = 0; i < 31; i++) step(1'b1, (i % 2) == 0, 1'b0, 1'b0);
    chk("alt_not_yet_valid", 32'(word_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("alt_word", word_out, 32'hAAAAAAAA);
    chk("alt_valid", 32'(word_valid), 32'h1);
    chk("alt_count", 32'(fifo_count), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);   // pop with empty FIFO is ignored

    // five words with no consumer: last one dropped
    for (int w = 0; w < 5; w++) send_word($urandom, 1'b0);
    chk("ovf_count", 32'(fifo_count), 32'h4);
    chk("ovf_flag", 32'(overflow), 32'h1);
    for (int w = 0; w < 4; w++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_drained", 32'(fifo_count), 32'h0);

    // full FIFO with push and pop on the same edge
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int w = 0; w < 4; w++) send_word($urandom, 1'b0);
    send_word(32'h5EED0042, 1'b1);
    chk("coin_count", 32'(fifo_count), 32'h4);
    chk("coin_ovf", 32'(overflow), 32'h0);
    for (int w = 0; w < 3; w++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("coin_last", word_out, 32'h5EED0042);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // partial word discarded by flush
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("flush_count", 32'(fifo_count), 32'h0);
    send_word(32'h12345678, 1'b0);
    chk("flush_word", word_out, 32'h12345678);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // low-ones word for the health test
    send_word(32'h00000001, 1'b0);
    chk("health_word", word_out, 32'h00000001);
`ifdef HEALTH_TEST_EN
    chk("health_flag", 32'(health_fail), 32'h1);
`else
    chk("health_flag", 32'(health_fail), 32'h0);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // asynchronous reset mid-word with two words buffered
    send_word(32'hDEADBEEF, 1'b0);
    send_word(32'h0BADF00D, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(fifo_count), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    send_word(32'hC0FFEE11, 1'b0);
    chk("post_rst_word", word_out, 32'hC0FFEE11);
    chk("post_rst_count", 32'(fifo_count), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
